// File: rtl/btn_pkg.sv
// Shared types and default timing constants for the push-button conditioner.
package btn_pkg;

  typedef enum logic [1:0] {
    RELEASED  = 2'd0,
    HELD      = 2'd1,
    REPEATING = 2'd2
  } btn_state_t;

  localparam int BTN_DB_TICKS   = 10;
  localparam int BTN_RPT_DELAY  = 5;
  localparam int BTN_RPT_PERIOD = 2;

endpackage

// File: rtl/btn_chan.sv
// One button channel: two-flop synchroniser, tick-paced debounce and the
// press / hold-to-repeat / release state machine with registered pulses.
module btn_chan
  import btn_pkg::*;
#(
  parameter int DB_TICKS   = BTN_DB_TICKS,
  parameter int RPT_DELAY  = BTN_RPT_DELAY,
  parameter int RPT_PERIOD = BTN_RPT_PERIOD
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  input  logic tick,
  input  logic rpt_en,
  output logic level,
  output logic press,
  output logic release_pulse,
  output logic press_next
);

  localparam int DB_W    = $clog2(DB_TICKS + 1);
  localparam int RPT_MAX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DB_TICKS - 1);
  localparam logic [DB_W-1:0]  DB_ONE     = DB_W'(1);
  localparam logic [RPT_W-1:0] RPT_ONE    = RPT_W'(1);
  localparam logic [RPT_W-1:0] RPT_LD_DLY = RPT_W'(RPT_DELAY);
  localparam logic [RPT_W-1:0] RPT_LD_PER = RPT_W'(RPT_PERIOD);

  logic [1:0]       sync_r;
  logic [DB_W-1:0]  db_cnt_r, db_cnt_s;
  logic             level_r, level_s;
  logic             accept_s;
  btn_state_t       state_r, state_s;
  logic [RPT_W-1:0] rpt_cnt_r, rpt_cnt_s;
  logic             press_r, press_s;
  logic             release_r, release_s;

  // Two-flop synchroniser; sync_r[1] is the stage seen by the debouncer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= 2'b00;
    end else begin
      sync_r <= {sync_r[0], raw};
    end
  end

  // Next-state: debounce counter, accepted level and press/repeat/release FSM.
  always_comb begin
    db_cnt_s  = db_cnt_r;
    level_s   = level_r;
    accept_s  = 1'b0;
    state_s   = state_r;
    rpt_cnt_s = rpt_cnt_r;
    press_s   = 1'b0;
    release_s = 1'b0;

    // A mismatch must persist for DB_TICKS ticks; agreement restarts the count.
    if (sync_r[1] == level_r) begin
      db_cnt_s = '0;
    end else if (tick) begin
      if (db_cnt_r == DB_LAST) begin
        db_cnt_s = '0;
        level_s  = sync_r[1];
        accept_s = 1'b1;
      end else begin
        db_cnt_s = db_cnt_r + DB_ONE;
      end
    end else begin
      db_cnt_s = db_cnt_r;
    end

    case (state_r)
      RELEASED: begin
        if (accept_s && sync_r[1]) begin
          state_s   = HELD;
          press_s   = 1'b1;
          rpt_cnt_s = RPT_LD_DLY;
        end else begin
          state_s = RELEASED;
        end
      end
      HELD, REPEATING: begin
        // Release acceptance takes priority over a coincident repeat expiry.
        if (accept_s && !sync_r[1]) begin
          state_s   = RELEASED;
          release_s = 1'b1;
          rpt_cnt_s = '0;
        end else if (tick && rpt_en) begin
          if (rpt_cnt_r == RPT_ONE) begin
            state_s   = REPEATING;
            press_s   = 1'b1;
            rpt_cnt_s = RPT_LD_PER;
          end else begin
            rpt_cnt_s = rpt_cnt_r - RPT_ONE;
          end
        end else begin
          state_s = state_r;
        end
      end
      default: begin
        state_s   = RELEASED;
        rpt_cnt_s = '0;
      end
    endcase
  end

  // State and registered output pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt_r  <= '0;
      level_r   <= 1'b0;
      state_r   <= RELEASED;
      rpt_cnt_r <= '0;
      press_r   <= 1'b0;
      release_r <= 1'b0;
    end else begin
      db_cnt_r  <= db_cnt_s;
      level_r   <= level_s;
      state_r   <= state_s;
      rpt_cnt_r <= rpt_cnt_s;
      press_r   <= press_s;
      release_r <= release_s;
    end
  end

  assign level         = level_r;
  assign press         = press_r;
  assign release_pulse = release_r;
  assign press_next    = press_s;

endmodule

// File: rtl/btn_conditioner.sv
// Conditions N_BTN raw push-buttons: one btn_chan per button plus a
// registered OR of the press pulses aligned with btn_press.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int N_BTN      = 4,
  parameter int DB_TICKS   = BTN_DB_TICKS,
  parameter int RPT_DELAY  = BTN_RPT_DELAY,
  parameter int RPT_PERIOD = BTN_RPT_PERIOD
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic             tick,
  input  logic [N_BTN-1:0] rpt_en,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic             any_press
);

  logic [N_BTN-1:0] press_next_s;
  logic             any_press_r;

  for (genvar i = 0; i < N_BTN; i++) begin : g_chan
    btn_chan #(
      .DB_TICKS  (DB_TICKS),
      .RPT_DELAY (RPT_DELAY),
      .RPT_PERIOD(RPT_PERIOD)
    ) u_chan (
      .clk          (clk),
      .rst_n        (rst_n),
      .raw          (btn_raw[i]),
      .tick         (tick),
      .rpt_en       (rpt_en[i]),
      .level        (btn_level[i]),
      .press        (btn_press[i]),
      .release_pulse(btn_release[i]),
      .press_next   (press_next_s[i])
    );
  end

  // OR of next-cycle presses so any_press lands in the same cycle as btn_press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      any_press_r <= 1'b0;
    end else begin
      any_press_r <= |press_next_s;
    end
  end

  assign any_press = any_press_r;

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with DB_TICKS=3, RPT_DELAY=5, RPT_PERIOD=2.
module tb_btn_conditioner;

  logic       clk;
  logic       rst_n;
  logic [3:0] btn_raw;
  logic       tick;
  logic [3:0] rpt_en;
  logic [3:0] btn_level;
  logic [3:0] btn_press;
  logic [3:0] btn_release;
  logic       any_press;

  int checks   = 0;
  int failures = 0;
  int phase    = 0;
  bit div4     = 1'b0;
  int found;
  logic [3:0] exp_p;

  btn_conditioner #(
    .N_BTN     (4),
    .DB_TICKS  (3),
    .RPT_DELAY (5),
    .RPT_PERIOD(2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_raw    (btn_raw),
    .tick       (tick),
    .rpt_en     (rpt_en),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .any_press  (any_press)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, settle, then set tick for the next edge.
  task automatic cyc();
    @(posedge clk);
    #1;
    phase++;
    if (div4) tick = ((phase % 4) == 0);
    else      tick = 1'b1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_level"},   32'(btn_level),   32'd0);
    chk({tag, "_press"},   32'(btn_press),   32'd0);
    chk({tag, "_release"}, 32'(btn_release), 32'd0);
    chk({tag, "_any"},     32'(any_press),   32'd0);
  endtask

  initial begin
    rst_n   = 1'b0;
    btn_raw = 4'h0;
    tick    = 1'b1;
    rpt_en  = 4'h0;
    #3;
    chk_all_zero("reset_async");
    cyc();
    cyc();
    chk_all_zero("reset_held");
    rst_n = 1'b1;
    cyc();
    chk_all_zero("reset_exit");

    // Clean press and release on channel 0.
    btn_raw[0] = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      cyc();
      chk("clean_press", 32'(btn_press[0]), (k == 5) ? 32'd1 : 32'd0);
      chk("clean_any",   32'(any_press),    (k == 5) ? 32'd1 : 32'd0);
      chk("clean_level", 32'(btn_level[0]), (k >= 5) ? 32'd1 : 32'd0);
    end
    btn_raw[0] = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      cyc();
      chk("clean_release", 32'(btn_release[0]), (k == 5) ? 32'd1 : 32'd0);
      chk("clean_rel_lvl", 32'(btn_level[0]),   (k >= 5) ? 32'd0 : 32'd1);
      chk("clean_rel_prs", 32'(btn_press[0]),   32'd0);
    end

    // Glitch of 2 cycles on channel 1 is rejected.
    btn_raw[1] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      if (k == 2) btn_raw[1] = 1'b0;
      chk("glitch_level", 32'(btn_level[1]), 32'd0);
      chk("glitch_press", 32'(btn_press[1]), 32'd0);
    end
    // Five cycles high is accepted; release follows 5 edges after it drops.
    btn_raw[1] = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      cyc();
      if (k == 5) btn_raw[1] = 1'b0;
      chk("long_press",   32'(btn_press[1]),   (k == 5) ? 32'd1 : 32'd0);
      chk("long_release", 32'(btn_release[1]), (k == 10) ? 32'd1 : 32'd0);
      chk("long_level",   32'(btn_level[1]),   (k >= 5 && k < 10) ? 32'd1 : 32'd0);
    end

    // Auto-repeat on channel 2 with a tick every 4th cycle.
    div4    = 1'b1;
    tick    = 1'b0;
    rpt_en  = 4'b0100;
    btn_raw = 4'b0100;
    found   = 0;
    for (int n = 0; n < 60 && found == 0; n++) begin
      cyc();
      if (btn_press[2]) found = 1;
    end
    chk("rpt_accept", 32'(found), 32'd1);
    chk("rpt_accept_any", 32'(any_press), 32'd1);
    for (int k = 1; k <= 84; k++) begin
      cyc();
      exp_p = (k == 20 || k == 28 || k == 36 || k == 68) ? 4'b0100 : 4'b0000;
      chk("rpt_press",   32'(btn_press),   32'(exp_p));
      chk("rpt_any",     32'(any_press),   32'(|exp_p));
      chk("rpt_release", 32'(btn_release), (k == 76) ? 32'h4 : 32'h0);
      chk("rpt_level",   32'(btn_level),   (k < 76) ? 32'h4 : 32'h0);
      if (k == 38) rpt_en[2] = 1'b0;
      if (k == 62) rpt_en[2] = 1'b1;
      if (k == 65) btn_raw[2] = 1'b0;
    end

    // All four buttons on the same edge.
    div4    = 1'b0;
    tick    = 1'b1;
    rpt_en  = 4'h0;
    cyc();
    btn_raw = 4'hF;
    for (int k = 1; k <= 6; k++) begin
      cyc();
      chk("simul_press", 32'(btn_press), (k == 5) ? 32'hF : 32'h0);
      chk("simul_any",   32'(any_press), (k == 5) ? 32'd1 : 32'd0);
      chk("simul_level", 32'(btn_level), (k >= 5) ? 32'hF : 32'h0);
    end

    // Reset mid-repeat with buttons held, then full latency on exit.
    rpt_en = 4'hF;
    cyc();
    cyc();
    cyc();
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst_mid_rpt");
    cyc();
    cyc();
    chk_all_zero("rst_mid_rpt_held");
    rst_n = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      cyc();
      chk("rst_exit_press", 32'(btn_press),   (k == 5) ? 32'hF : 32'h0);
      chk("rst_exit_level", 32'(btn_level),   (k >= 5) ? 32'hF : 32'h0);
      chk("rst_exit_rel",   32'(btn_release), 32'h0);
    end

    // Reset mid-debounce of a release discards it silently.
    rpt_en  = 4'h0;
    btn_raw = 4'h0;
    cyc();
    cyc();
    cyc();
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst_mid_db");
    cyc();
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      chk_all_zero("rst_mid_db_exit");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
